// File: rtl/ipu_frame_sched.sv
// Frame scheduler in front of the IPU red-centroid unit: decimates camera frames, gates pixels
// into the IPU, waits for its result with a watchdog, and holds it in a 1-deep valid/ready slot.
// Optional frame statistics ports are enabled by defining IPU_SCHED_STATS_EN.
module ipu_frame_sched #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEnable,
  input  logic [3:0]  iDecim,
  input  logic        iDVAL,
  input  logic [10:0] iX_Cont,
  input  logic [10:0] iY_Cont,
  output logic        oIPU_DVAL,
  output logic [10:0] oIPU_X,
  output logic [10:0] oIPU_Y,
  output logic        oIPU_CLR,
  input  logic [10:0] iIPU_X,
  input  logic [10:0] iIPU_Y,
  input  logic        iIPU_DVAL,
  output logic [10:0] oX,
  output logic [10:0] oY,
  output logic        oVALID,
  input  logic        iREADY,
  output logic        oBusy,
  output logic        oTimeout,
  output logic [7:0]  oDrop_cnt
`ifdef IPU_SCHED_STATS_EN
  ,
  output logic [15:0] oFrm_seen,
  output logic [15:0] oFrm_done
`endif
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_SOF = 2'd1;
  localparam logic [1:0] S_STREAM   = 2'd2;
  localparam logic [1:0] S_WAIT_RES = 2'd3;
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [1:0]    state_q, state_d;
  logic [3:0]    dcnt_q, dcnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ipu_dval_q, ipu_dval_d;
  logic          ipu_clr_q, ipu_clr_d;
  logic [10:0]   ipu_x_q, ipu_x_d, ipu_y_q, ipu_y_d;
  logic [10:0]   res_x_q, res_x_d, res_y_q, res_y_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    drop_q, drop_d;

  logic       sof, eof, capture, pop;
  logic [3:0] decim_eff;

  assign sof       = iDVAL && (iX_Cont == 11'd0) && (iY_Cont == 11'd0);
  assign eof       = iDVAL && (iX_Cont == 11'(H_ACTIVE - 1)) && (iY_Cont == 11'(V_ACTIVE - 1));
  assign decim_eff = (iDecim == 4'd0) ? 4'd1 : iDecim;
  assign pop       = valid_q && iREADY;
  assign ipu_x_d   = iX_Cont;
  assign ipu_y_d   = iY_Cont;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    timer_d    = timer_q;
    timeout_d  = timeout_q;
    ipu_dval_d = 1'b0;
    ipu_clr_d  = 1'b0;
    capture    = 1'b0;
    case (state_q)
      S_IDLE: if (iEnable) state_d = S_WAIT_SOF;
      S_WAIT_SOF: begin
        if (!iEnable) begin
          state_d = S_IDLE;
        end else if (sof) begin
          dcnt_d = 4'((5'(dcnt_q) + 5'd1) % {1'b0, decim_eff});
          if (dcnt_q == 4'd0) begin
            state_d    = S_STREAM;
            ipu_dval_d = 1'b1;
            ipu_clr_d  = 1'b1;
          end
        end
      end
      S_STREAM: begin
        // A SOF here means the previous frame was truncated; restart accumulation on it.
        ipu_dval_d = iDVAL;
        ipu_clr_d  = sof;
        if (eof) begin
          state_d = S_WAIT_RES;
          timer_d = '0;
        end
      end
      S_WAIT_RES: begin
        timer_d = timer_q + TW'(1);
        if (iIPU_DVAL) begin
          capture   = 1'b1;
          timeout_d = 1'b0;
          state_d   = iEnable ? S_WAIT_SOF : S_IDLE;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          state_d   = iEnable ? S_WAIT_SOF : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res_x_d = res_x_q;
    res_y_d = res_y_q;
    valid_d = valid_q && !pop;
    drop_d  = drop_q;
    if (capture) begin
      if (!valid_q || pop) begin
        res_x_d = iIPU_X;
        res_y_d = iIPU_Y;
        valid_d = 1'b1;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= S_IDLE;
      dcnt_q     <= '0;
      timer_q    <= '0;
      ipu_dval_q <= 1'b0;
      ipu_clr_q  <= 1'b0;
      ipu_x_q    <= '0;
      ipu_y_q    <= '0;
      res_x_q    <= '0;
      res_y_q    <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      timer_q    <= timer_d;
      ipu_dval_q <= ipu_dval_d;
      ipu_clr_q  <= ipu_clr_d;
      ipu_x_q    <= ipu_x_d;
      ipu_y_q    <= ipu_y_d;
      res_x_q    <= res_x_d;
      res_y_q    <= res_y_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      drop_q     <= drop_d;
    end
  end

  assign oIPU_DVAL = ipu_dval_q;
  assign oIPU_CLR  = ipu_clr_q;
  assign oIPU_X    = ipu_x_q;
  assign oIPU_Y    = ipu_y_q;
  assign oX        = res_x_q;
  assign oY        = res_y_q;
  assign oVALID    = valid_q;
  assign oTimeout  = timeout_q;
  assign oDrop_cnt = drop_q;
  assign oBusy     = (state_q != S_IDLE);

`ifdef IPU_SCHED_STATS_EN
  logic [15:0] seen_q, seen_d, done_q, done_d;

  always_comb begin
    seen_d = seen_q + {15'd0, sof && (state_q != S_IDLE)};
    done_d = done_q + {15'd0, capture};
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      seen_q <= '0;
      done_q <= '0;
    end else begin
      seen_q <= seen_d;
      done_q <= done_d;
    end
  end

  assign oFrm_seen = seen_q;
  assign oFrm_done = done_q;
`endif

endmodule

// File: tb/tb_ipu_frame_sched.sv
// Self-checking bench for ipu_frame_sched on a reduced 8x6 frame: random pixel gaps and
// IPU results, checked against a frame-level model (selection by frame index, result slot).
`timescale 1ns/1ps
module tb_ipu_frame_sched;
  localparam int H  = 8;
  localparam int V  = 6;
  localparam int TO = 32;

  logic        iCLK = 1'b0;
  logic        iRST, iEnable, iDVAL, iIPU_DVAL, iREADY;
  logic [3:0]  iDecim;
  logic [10:0] iX_Cont, iY_Cont, iIPU_X, iIPU_Y;
  logic        oIPU_DVAL, oIPU_CLR, oVALID, oBusy, oTimeout;
  logic [10:0] oIPU_X, oIPU_Y, oX, oY;
  logic [7:0]  oDrop_cnt;
`ifdef IPU_SCHED_STATS_EN
  logic [15:0] oFrm_seen, oFrm_done;
`endif

  int errors = 0, checks = 0;
  int dval_cnt = 0, clr_cnt = 0, follow_err = 0;
  int fidx, m_dec, m_drop;
  bit m_valid;
  logic [10:0] m_x, m_y;

  always #5 iCLK = ~iCLK;

  ipu_frame_sched #(.H_ACTIVE(H), .V_ACTIVE(V), .TIMEOUT_CYC(TO)) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iEnable   (iEnable),
    .iDecim    (iDecim),
    .iDVAL     (iDVAL),
    .iX_Cont   (iX_Cont),
    .iY_Cont   (iY_Cont),
    .oIPU_DVAL (oIPU_DVAL),
    .oIPU_X    (oIPU_X),
    .oIPU_Y    (oIPU_Y),
    .oIPU_CLR  (oIPU_CLR),
    .iIPU_X    (iIPU_X),
    .iIPU_Y    (iIPU_Y),
    .iIPU_DVAL (iIPU_DVAL),
    .oX        (oX),
    .oY        (oY),
    .oVALID    (oVALID),
    .iREADY    (iREADY),
    .oBusy     (oBusy),
    .oTimeout  (oTimeout),
    .oDrop_cnt (oDrop_cnt)
`ifdef IPU_SCHED_STATS_EN
    ,
    .oFrm_seen (oFrm_seen),
    .oFrm_done (oFrm_done)
`endif
  );

  always @(posedge iCLK) begin
    #1;
    if (oIPU_DVAL === 1'b1) dval_cnt++;
    if (oIPU_CLR === 1'b1) clr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given pixel; the IPU-side copy must show it one edge later.
  task automatic px(input logic d, input logic [10:0] x, input logic [10:0] y);
    iDVAL = d; iX_Cont = x; iY_Cont = y;
    @(negedge iCLK);
    if (!iRST && (oIPU_X !== x || oIPU_Y !== y)) follow_err++;
  endtask

  task automatic idle(input int n);
    repeat (n) px(1'b0, 11'($urandom), 11'($urandom));
  endtask

  // A frame is selected when its index since the last reset is a multiple of max(iDecim,1).
  function automatic bit model_sof();
    bit s;
    s = (fidx % m_dec) == 0;
    fidx++;
    return s;
  endfunction

  task automatic do_reset(input logic [3:0] d);
    iRST = 1'b1; iEnable = 1'b0; iREADY = 1'b0; iIPU_DVAL = 1'b0;
    idle(2);
    iRST = 1'b0; iDecim = d; m_dec = (d == 4'd0) ? 1 : int'(d);
    fidx = 0; m_valid = 1'b0; m_drop = 0;
    iEnable = 1'b1;
    idle(2);
  endtask

  task automatic send_frame(input bit exp_sel, input int stop_row, input int en_off_row,
                            input int rst_row);
    int d0, c0;
    d0 = dval_cnt; c0 = clr_cnt;
    for (int y = 0; y < stop_row; y++) begin
      for (int x = 0; x < H; x++) begin
        if (y == en_off_row && x == 0) iEnable = 1'b0;
        if (y == rst_row && x == 0) begin
          iRST = 1'b1;
          px(1'b1, 11'(x), 11'(y));
          check("rst_ipu_dval", oIPU_DVAL, 0);
          check("rst_valid", oVALID, 0);
          check("rst_busy", oBusy, 0);
          iRST = 1'b0;
          fidx = 0; m_valid = 1'b0; m_drop = 0;
          return;
        end
        px(1'b1, 11'(x), 11'(y));
        if (x == 0 && y == 0) begin
          check("sof_clr", oIPU_CLR, 32'(exp_sel));
          check("sof_dval", oIPU_DVAL, 32'(exp_sel));
        end
        if (!(x == H - 1 && y == stop_row - 1) && $urandom_range(7) == 0) idle(1);
      end
    end
    if (stop_row == V) begin
      check("frm_dval_cnt", 32'(dval_cnt - d0), exp_sel ? 32'(H * V) : 32'd0);
      check("frm_clr_cnt", 32'(clr_cnt - c0), 32'(exp_sel));
    end
  endtask

  task automatic respond(input int lat, input logic [10:0] x, input logic [10:0] y);
    idle(lat);
    iIPU_X = x; iIPU_Y = y; iIPU_DVAL = 1'b1;
    idle(1);
    iIPU_DVAL = 1'b0; iIPU_X = 11'($urandom); iIPU_Y = 11'($urandom);
    if (!m_valid) begin
      m_valid = 1'b1; m_x = x; m_y = y;
    end else if (m_drop < 255) begin
      m_drop++;
    end
    idle(2);
  endtask

  task automatic pop_check(input string tag);
    check({tag, "_valid"}, oVALID, 32'(m_valid));
    if (m_valid) begin
      check({tag, "_x"}, oX, m_x);
      check({tag, "_y"}, oY, m_y);
    end
    check({tag, "_drop"}, oDrop_cnt, m_drop);
    iREADY = 1'b1;
    idle(1);
    iREADY = 1'b0;
    m_valid = 1'b0;
    check({tag, "_popped"}, oVALID, 0);
  endtask

  initial begin
    bit sel;
    iRST = 1'b1; iEnable = 1'b0; iDecim = 4'd1; iREADY = 1'b0;
    iIPU_DVAL = 1'b0; iIPU_X = '0; iIPU_Y = '0;
    idle(3);
    check("reset_ipu_dval", oIPU_DVAL, 0);
    check("reset_clr", oIPU_CLR, 0);
    check("reset_valid", oVALID, 0);
    check("reset_busy", oBusy, 0);
    check("reset_timeout", oTimeout, 0);
    check("reset_drop", oDrop_cnt, 0);
    check("reset_xy", {oX, oY}, 0);

    // Basic frame; a result offered outside WAIT_RES must be ignored.
    do_reset(4'd1);
    check("t1_busy_wait_sof", oBusy, 1);
    iIPU_X = 11'd5; iIPU_DVAL = 1'b1;
    idle(1);
    iIPU_DVAL = 1'b0;
    idle(1);
    check("t1_stray_result", oVALID, 0);
    send_frame(model_sof(), V, -1, -1);
    check("t1_busy_wait_res", oBusy, 1);
    respond(20, 11'd320, 11'd240);
    pop_check("t1");
    send_frame(model_sof(), V, -1, -1);
    respond(TO - 1, 11'($urandom), 11'($urandom));
    check("t1_last_cycle_result_no_timeout", oTimeout, 0);
    pop_check("t1b");

    // Decimation by 3, then iDecim=0 behaving as 1.
    do_reset(4'd3);
    for (int f = 0; f < 6; f++) begin
      sel = model_sof();
      send_frame(sel, V, -1, -1);
      if (sel) begin
        respond($urandom_range(1, 20), 11'($urandom), 11'($urandom));
        pop_check("t2");
      end else begin
        idle(8);
      end
    end
    do_reset(4'd0);
    for (int f = 0; f < 2; f++) begin
      send_frame(model_sof(), V, -1, -1);
      respond($urandom_range(1, 20), 11'($urandom), 11'($urandom));
      pop_check("t2_decim0");
    end

    // Full slot: first result held, later ones dropped, count saturating.
    do_reset(4'd1);
    for (int f = 0; f < 3; f++) begin
      send_frame(model_sof(), V, -1, -1);
      respond($urandom_range(1, 20), 11'($urandom), 11'($urandom));
      check("t3_hold_x", oX, m_x);
      check("t3_drop", oDrop_cnt, m_drop);
    end
    for (int f = 0; f < 256; f++) begin
      send_frame(model_sof(), V, -1, -1);
      respond($urandom_range(1, 8), 11'($urandom), 11'($urandom));
    end
    check("t3_drop_saturated", oDrop_cnt, m_drop);
    pop_check("t3");
    send_frame(model_sof(), V, -1, -1);
    respond($urandom_range(1, 20), 11'($urandom), 11'($urandom));
    pop_check("t3_refill");

    // Watchdog: flag rises TO edges after the forwarded EOF, cleared by a good result.
    do_reset(4'd1);
    send_frame(model_sof(), V, -1, -1);
    idle(TO - 1);
    check("t4_timeout_early", oTimeout, 0);
    idle(1);
    check("t4_timeout_set", oTimeout, 1);
    check("t4_no_capture", oVALID, 0);
    idle(3);
    send_frame(model_sof(), V, -1, -1);
    check("t4_timeout_sticky", oTimeout, 1);
    respond($urandom_range(1, 20), 11'($urandom), 11'($urandom));
    check("t4_timeout_cleared", oTimeout, 0);
    pop_check("t4");

    // Enable dropped mid-frame, then reset mid-frame with a full slot.
    do_reset(4'd1);
    send_frame(model_sof(), V, V / 2, -1);
    check("t5_busy_after_eof", oBusy, 1);
    respond($urandom_range(1, 20), 11'($urandom), 11'($urandom));
    check("t5_idle", oBusy, 0);
    check("t5_captured", oVALID, 32'(m_valid));
    check("t5_x", oX, m_x);
    send_frame(1'b0, V, -1, -1);
    iEnable = 1'b1;
    idle(2);
    send_frame(model_sof(), V, -1, 2);
    idle(2);

    // Truncated frame: a second SOF inside STREAM restarts the frame.
    do_reset(4'd1);
    begin
      int d0, c0;
      d0 = dval_cnt; c0 = clr_cnt;
      send_frame(model_sof(), V / 2, -1, -1);
      send_frame(1'b1, V, -1, -1);
      check("t6_busy_wait_res", oBusy, 1);
      check("t6_dval_total", 32'(dval_cnt - d0), 32'((V / 2) * H + H * V));
      check("t6_clr_total", 32'(clr_cnt - c0), 2);
    end
    respond($urandom_range(1, 20), 11'($urandom), 11'($urandom));
`ifdef IPU_SCHED_STATS_EN
    check("t6_frm_seen", oFrm_seen, 2);
    check("t6_frm_done", oFrm_done, 1);
`endif
    pop_check("t6");

    check("ipu_follow", follow_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
